// File: rtl/axi_read_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4 read-channel arbiter: round-robin grant,
// a single outstanding transaction, rlast/arlen beat checking and an R-phase watchdog.
module axi_read_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int ID_W    = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   // IFU master
   input  logic              ifu_arvalid,
   output logic              ifu_arready,
   input  logic [ADDR_W-1:0] ifu_araddr,
   input  logic [ID_W-1:0]   ifu_arid,
   input  logic [7:0]        ifu_arlen,
   input  logic [2:0]        ifu_arsize,
   input  logic [1:0]        ifu_arburst,
   input  logic              ifu_rready,
   output logic              ifu_rvalid,
   output logic [1:0]        ifu_rresp,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              ifu_rlast,
   output logic [ID_W-1:0]   ifu_rid,
   // LSU master
   input  logic              lsu_arvalid,
   output logic              lsu_arready,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic [ID_W-1:0]   lsu_arid,
   input  logic [7:0]        lsu_arlen,
   input  logic [2:0]        lsu_arsize,
   input  logic [1:0]        lsu_arburst,
   input  logic              lsu_rready,
   output logic              lsu_rvalid,
   output logic [1:0]        lsu_rresp,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_rlast,
   output logic [ID_W-1:0]   lsu_rid,
   // Slave port
   output logic              axi_arvalid,
   input  logic              axi_arready,
   output logic [ADDR_W-1:0] axi_araddr,
   output logic [ID_W-1:0]   axi_arid,
   output logic [7:0]        axi_arlen,
   output logic [2:0]        axi_arsize,
   output logic [1:0]        axi_arburst,
   output logic              axi_rready,
   input  logic              axi_rvalid,
   input  logic [1:0]        axi_rresp,
   input  logic [DATA_W-1:0] axi_rdata,
   input  logic              axi_rlast,
   input  logic [ID_W-1:0]   axi_rid,
   // Status
   output logic              owner,
   output logic              busy,
   output logic              proto_err,
   output logic              timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              prio_q, prio_d;
   logic [7:0]        len_q, len_d;
   logic [8:0]        beat_q, beat_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              proto_q, proto_d;
   logic              tout_q, tout_d;

   logic ar_act, r_act, abort, fwd_r, r_beat;
   logic own_arvalid, own_rready, grant_sel;
   logic to_ifu, to_lsu;

   assign ar_act      = (state_q == S_AR);
   assign r_act       = (state_q == S_R);
   assign own_arvalid = owner_q ? lsu_arvalid : ifu_arvalid;
   assign own_rready  = owner_q ? lsu_rready  : ifu_rready;
   assign grant_sel   = (ifu_arvalid && lsu_arvalid) ? prio_q : lsu_arvalid;

   // The abort cycle also hides the beat from the owner so both sides agree nothing moved.
   assign abort  = r_act && (wdog_q == WD_W'(TIMEOUT));
   assign fwd_r  = r_act && !abort;
   assign to_ifu = fwd_r && !owner_q;
   assign to_lsu = fwd_r &&  owner_q;
   assign r_beat = axi_rvalid && axi_rready;

   assign axi_arvalid = ar_act && own_arvalid;
   assign axi_araddr  = !ar_act ? '0 : (owner_q ? lsu_araddr  : ifu_araddr);
   assign axi_arid    = !ar_act ? '0 : (owner_q ? lsu_arid    : ifu_arid);
   assign axi_arlen   = !ar_act ? '0 : (owner_q ? lsu_arlen   : ifu_arlen);
   assign axi_arsize  = !ar_act ? '0 : (owner_q ? lsu_arsize  : ifu_arsize);
   assign axi_arburst = !ar_act ? '0 : (owner_q ? lsu_arburst : ifu_arburst);
   assign ifu_arready = ar_act && !owner_q && axi_arready;
   assign lsu_arready = ar_act &&  owner_q && axi_arready;

   assign axi_rready = fwd_r && own_rready;
   assign ifu_rvalid = to_ifu && axi_rvalid;
   assign ifu_rresp  = to_ifu ? axi_rresp : '0;
   assign ifu_rdata  = to_ifu ? axi_rdata : '0;
   assign ifu_rlast  = to_ifu && axi_rlast;
   assign ifu_rid    = to_ifu ? axi_rid   : '0;
   assign lsu_rvalid = to_lsu && axi_rvalid;
   assign lsu_rresp  = to_lsu ? axi_rresp : '0;
   assign lsu_rdata  = to_lsu ? axi_rdata : '0;
   assign lsu_rlast  = to_lsu && axi_rlast;
   assign lsu_rid    = to_lsu ? axi_rid   : '0;

   assign owner       = owner_q;
   assign busy        = (state_q != S_IDLE);
   assign proto_err   = proto_q;
   assign timeout_err = tout_q;

   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
      state_d = state_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      len_d   = len_q;
      beat_d  = beat_q;
      wdog_d  = wdog_q;
      proto_d = proto_q;
      tout_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (ifu_arvalid || lsu_arvalid) begin
               owner_d = grant_sel;
               len_d   = grant_sel ? lsu_arlen : ifu_arlen;
               state_d = S_AR;
            end
         end
         S_AR: begin
            if (axi_arvalid && axi_arready) begin
               state_d = S_R;
               beat_d  = '0;
               wdog_d  = '0;
            end else if (!own_arvalid) begin
               state_d = S_IDLE;
            end
         end
         S_R: begin
            if (abort) begin
               state_d = S_IDLE;
               tout_d  = 1'b1;
            end else if (r_beat) begin
               beat_d = beat_q + 9'd1;
               wdog_d = '0;
               if (axi_rlast != (beat_q == {1'b0, len_q})) proto_d = 1'b1;
               if (axi_rlast) begin
                  state_d = S_IDLE;
                  prio_d  = ~owner_q;
               end
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
         len_q   <= '0;
         beat_q  <= '0;
         wdog_q  <= '0;
         proto_q <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         wdog_q  <= wdog_d;
         proto_q <= proto_d;
         tout_q  <= tout_d;
      end
   end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Two-master, one-slave AXI4 read-channel arbiter that shares the core's single external read port between the instruction fetch path (IFU cache-miss fetch) and the load/store unit (LSU).
- Allows one outstanding transaction at a time. The owner is locked from AR grant until the final R beat handshakes.
- Uses round-robin priority, a beat counter that checks rlast against arlen, and an R-phase watchdog.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, read data width.
- ID_W, 4, AXI ID width.
- TIMEOUT, 1023, max idle cycles in R phase before abort (counter width clog2(TIMEOUT+1)).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- ifu_arvalid/ifu_arready  in/out  1/1  IFU AR handshake.
- ifu_araddr/ifu_arid/ifu_arlen/ifu_arsize/ifu_arburst  in  ADDR_W/ID_W/8/3/2  IFU AR payload.
- ifu_rready/ifu_rvalid  in/out  1/1  IFU R handshake.
- ifu_rresp/ifu_rdata/ifu_rlast/ifu_rid  out  2/DATA_W/1/ID_W  IFU R payload.
- lsu_*  (same set, same directions and widths as ifu_*)  LSU master.
- axi_arvalid/axi_arready  out/in  1/1  slave AR handshake.
- axi_araddr/axi_arid/axi_arlen/axi_arsize/axi_arburst  out  ADDR_W/ID_W/8/3/2  slave AR payload.
- axi_rready/axi_rvalid  out/in  1/1  slave R handshake.
- axi_rresp/axi_rdata/axi_rlast/axi_rid  in  2/DATA_W/1/ID_W  slave R payload.
- owner  out  1  current grant: 0 = IFU, 1 = LSU (valid when busy).
- busy  out  1  arbiter is not in IDLE.
- proto_err  out  1  sticky; rlast did not coincide with the final expected beat.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, owner=0, prio=IFU-first, beat_cnt=0, wdog=0.
  - proto_err=0, timeout_err=0.
  - All outbound valid/ready=0 and all payload outputs=0.
- States: IDLE, AR, R.
- IDLE:
  - Routes nothing; ifu/lsu arready=0.
  - If exactly one master has arvalid, grant it.
  - If both have arvalid, grant the prio master.
  - On grant: register owner, latch the owner's arlen into len_q, go to AR. Arbitration latency is exactly 1 cycle.
- AR:
  - axi_ar* = owner's ar* (combinational mux).
  - owner arready = axi_arready; the non-owner arready=0.
  - On axi_arvalid&axi_arready: go to R, beat_cnt=0, wdog=0.
  - If owner arvalid drops before handshake (pipeline flush), return to IDLE with no transaction issued. prio is unchanged.
- R:
  - axi_rready = owner rready.
  - Owner receives rvalid/rresp/rdata/rlast/rid unchanged; the non-owner rvalid=0 and its payload=0.
  - Each beat (rvalid&rready): beat_cnt+1, wdog=0. Otherwise wdog+1.
  - A beat with rlast=1 returns to IDLE, and prio flips to the non-owner.
  - proto_err sets if rlast=1 while beat_cnt!=len_q, or rlast=0 while beat_cnt==len_q.
  - If rlast is missing past beat len_q, stay in R until rlast or timeout.
  - When wdog==TIMEOUT: pulse timeout_err, force IDLE, set axi_rready=0 that cycle. Late beats after abort are dropped (axi_rready=0 in IDLE).
- Simultaneous events:
  - A new request arriving in the same cycle as the final rlast beat is not granted until the next cycle. IDLE lasts at least 1 cycle between transactions.
  - A non-owner arvalid during AR/R is held off (arready=0) and does not affect the current transaction.
- busy = (state!=IDLE).
- Async reset mid-transaction aborts immediately to the reset values. The slave is not notified.

Test Plan:
- IFU only: ifu_arvalid, araddr=0x8000_0008, arlen=0; slave arready after 2 cycles, single beat rdata=0x1111_2222_3333_4444, rlast=1 -> grant 1 cycle after arvalid; ifu_rvalid pulses with that data; busy drops; lsu_rvalid stays 0.
- Contention: both arvalid in the same IDLE cycle from reset -> IFU served first, then LSU granted on the next IDLE cycle. A second contention after that grants IFU (round-robin alternation).
- Burst: LSU arlen=3, four beats with rlast on the 4th -> all four forwarded in order and proto_err=0. Repeat with rlast on the 3rd beat -> proto_err=1 (sticky) and return to IDLE.
- Flush: IFU granted, ifu_arvalid drops before axi_arready -> state IDLE next cycle, no axi AR handshake, LSU request then granted.
- Timeout (TIMEOUT=8 in bench): AR accepted, no rvalid for 8 cycles -> timeout_err one-cycle pulse, busy=0; a late rvalid is ignored (axi_rready=0).
- Async reset asserted mid-R -> all outputs return to reset values without waiting for a clock edge; the next request is granted normally after release.
